bin2bcd_seq: RTL and testbench
==============================

Name: bin2bcd_seq

Overview:
Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) algorithm, one binary bit per clock. It is the producer side of the BCD digit bus consumed by the per-digit seven-segment decoders. It converts counters and pixel and debug values from the vjtag path into packed BCD digits for the board displays. A start/busy/done handshake lets a controller launch a conversion and latch the held result.

Parameters:
BIN_WIDTH, 16, width of the unsigned binary input; minimum 1.
DIGITS, 5, number of BCD output digits; the output is 4*DIGITS bits wide.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  request a conversion; sampled only while idle.
bin_in  input  BIN_WIDTH  unsigned value to convert; sampled on the edge that accepts start.
busy  output  1  high while a conversion is in progress.
done  output  1  one-cycle pulse when bcd_out and overflow become valid.
bcd_out  output  4*DIGITS  packed BCD; digit 0 (ones) is in bits [3:0]; held between conversions.
overflow  output  1  set when the latched input exceeds 10^DIGITS-1; valid with done and held.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE.
  - busy=0, done=0, bcd_out=0, overflow=0; the scratch register and bit counter clear.
  - Reset takes priority over every other input, including in the middle of a conversion. The aborted conversion produces no done pulse.
- States: IDLE and SHIFT.
- IDLE:
  - busy=0.
  - On an edge with start=1:
    - latch bin_in into the shift register.
    - clear the BCD scratch digits.
    - load bit_cnt=BIN_WIDTH.
    - precompute the overflow condition from the latched value against the constant 10^DIGITS-1.
    - go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT:
  - busy=1 and start is ignored. bin_in is don't-care.
  - Each edge applies two steps, in order:
    - every scratch digit with a value of 5 or more gets 3 added (4-bit, no carry out of the nibble).
    - then the concatenation {scratch, shift register} shifts left by 1.
  - bit_cnt decrements on each of these edges.
  - On the edge where bit_cnt goes from 1 to 0:
    - bcd_out takes the post-shift scratch, or all digits = 9 if overflow.
    - overflow output updates, done=1, busy=0, state goes to IDLE.
- Latency: the start-accept edge is E0. Shifts happen on E1..E_BIN_WIDTH. done is high for exactly the cycle after E_BIN_WIDTH, giving BIN_WIDTH cycles from accept to done.
- done is a single-cycle pulse and is 0 in every other cycle.
- Back-to-back operation: in the done cycle the state is already IDLE, so start=1 in that cycle is accepted. The new conversion begins while bcd_out still holds the previous result until its own done.
- Overflow saturation: when overflow=1, bcd_out = all digits 4'h9.
- Every emitted digit is in the range 0..9, so no error code ever reaches a downstream decoder.
- bcd_out and overflow change only on a done edge or reset.
- Scratch width is 4*DIGITS. The overflow flag comes from the compare, not from a carry out of the scratch register.

Test Plan:
1. Defaults; reset, then start with bin_in=0 → done exactly 16 cycles after accept; bcd_out=20'h00000; overflow=0; busy high for 16 cycles.
2. Defaults; bin_in=16'd65535 → bcd_out=20'h65535, overflow=0. Then bin_in=16'd1234 → bcd_out=20'h01234, and bcd_out holds 20'h65535 until the second done.
3. Defaults; start with 16'd999, then pulse start with bin_in=16'd42 in mid-conversion → the second start is ignored; result 20'h00999 at cycle 16; only one done pulse.
4. Defaults; start with 16'd5000, assert rst at cycle 8 → busy=0, bcd_out=0, no done. A following start with 16'd7 gives 20'h00007 after 16 cycles.
5. BIN_WIDTH=16, DIGITS=4; bin_in=16'd12345 → done after 16 cycles, overflow=1, bcd_out=16'h9999. Then bin_in=16'd9999 → overflow=0, bcd_out=16'h9999.
6. Back-to-back: assert start with 16'd10 in the done cycle of the prior conversion (16'd321) → bcd_out 20'h00321, then 20'h00010, with done pulses exactly 16 cycles apart.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// start/busy/done handshake; result and overflow flag held until the next done.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int CMP_W = (BIN_WIDTH > BCD_W) ? BIN_WIDTH : BCD_W;

  // 10^DIGITS-1 always fits in 4*DIGITS bits, so CMP_W holds both operands.
  function automatic logic [CMP_W-1:0] max_value(input int digits);
    logic [CMP_W-1:0] v;
    v = CMP_W'(1);
    for (int i = 0; i < digits; i++) v = v * CMP_W'(10);
    return v - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_VAL  = max_value(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_WIDTH);
  localparam logic [BCD_W-1:0] ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adj;
  logic [BCD_W-1:0]     next_scratch;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 ovf_pend;
  logic                 last_shift;

  // NOTE: state and datapath registers use non-blocking assignments only, so
  // every flop samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each always_comb assigns its outputs a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_shift) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  assign last_shift = (state == SHIFT) && (bit_cnt == CNT_W'(1));

  // Add-3 correction on every digit >= 5, then shift the next binary bit in.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  assign next_scratch = {adj[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};

  // NOTE: every register here is a plain flop (no memory array), so all of
  // them clear on reset, including scratch and bit_cnt.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      scratch   <= '0;
      bit_cnt   <= '0;
      ovf_pend  <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= CNT_LOAD;
            ovf_pend  <= (CMP_W'(bin_in) > MAX_VAL);
          end
        end
        SHIFT: begin
          scratch   <= next_scratch;
          shift_reg <= shift_reg << 1;
          bit_cnt   <= bit_cnt - CNT_W'(1);
          if (last_shift) begin
            bcd_out  <= ovf_pend ? ALL_NINE : next_scratch;
            overflow <= ovf_pend;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: a 5-digit (default) and a 4-digit instance
// checked against hand-computed BCD values, latency, hold and reset behaviour.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start5, start4;
  logic [15:0] bin5, bin4;
  logic        busy5, done5, ovf5;
  logic [19:0] bcd5;
  logic        busy4, done4, ovf4;
  logic [15:0] bcd4;

  bin2bcd_seq dut5 (
    .clk(clk), .rst(rst), .start(start5), .bin_in(bin5),
    .busy(busy5), .done(done5), .bcd_out(bcd5), .overflow(ovf5)
  );

  bin2bcd_seq #(.BIN_WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
    .busy(busy4), .done(done4), .bcd_out(bcd4), .overflow(ovf4)
  );

  int          sel;
  logic        busy_m, done_m, ovf_m;
  logic [19:0] bcd_m;

  always_comb begin
    if (sel == 1) begin
      busy_m = busy4; done_m = done4; ovf_m = ovf4; bcd_m = {4'h0, bcd4};
    end else begin
      busy_m = busy5; done_m = done5; ovf_m = ovf5; bcd_m = bcd5;
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [19:0] prev_bcd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [15:0] v);
    if (sel == 1) begin start4 = 1'b1; bin4 = v; end
    else          begin start5 = 1'b1; bin5 = v; end
    @(negedge clk);
    start4 = 1'b0; start5 = 1'b0;
    bin4 = 16'hA5A5; bin5 = 16'hA5A5;
  endtask

  // Called one negedge after the accept edge; returns cycles until done.
  task automatic wait_done(output int lat, output int busy_cnt, output logic held);
    lat = 0; busy_cnt = 0; held = 1'b1;
    while (!done_m && lat < 40) begin
      if (busy_m) busy_cnt++;
      if (bcd_m !== prev_bcd) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic conv(input string name, input logic [15:0] v,
                      input logic [19:0] exp_bcd, input logic exp_ovf);
    int lat, bc;
    logic held;
    launch(v);
    wait_done(lat, bc, held);
    check({name, "_lat"}, lat, 16);
    check({name, "_busy_cycles"}, bc, 16);
    check({name, "_hold"}, held, 1);
    check({name, "_bcd"}, bcd_m, exp_bcd);
    check({name, "_ovf"}, ovf_m, exp_ovf);
    check({name, "_busy_at_done"}, busy_m, 0);
    prev_bcd = exp_bcd;
    @(negedge clk);
    check({name, "_pulse"}, done_m, 0);
  endtask

  typedef struct {
    logic [15:0] bin;
    logic [19:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int   lat, bc, pulses, d_lat;
    logic held;
    logic [19:0] got;

    vecs[0]  = '{16'd0,     20'h00000, 1'b0};
    vecs[1]  = '{16'd65535, 20'h65535, 1'b0};
    vecs[2]  = '{16'd1234,  20'h01234, 1'b0};
    vecs[3]  = '{16'd1,     20'h00001, 1'b0};
    vecs[4]  = '{16'd9,     20'h00009, 1'b0};
    vecs[5]  = '{16'd10,    20'h00010, 1'b0};
    vecs[6]  = '{16'd4095,  20'h04095, 1'b0};
    vecs[7]  = '{16'd9999,  20'h09999, 1'b0};
    vecs[8]  = '{16'd10000, 20'h10000, 1'b0};
    vecs[9]  = '{16'd32768, 20'h32768, 1'b0};
    vecs[10] = '{16'd50000, 20'h50000, 1'b0};
    vecs[11] = '{16'd59999, 20'h59999, 1'b0};

    sel = 0; rst = 1'b1;
    start5 = 1'b0; start4 = 1'b0; bin5 = '0; bin4 = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy5, 0);
    check("rst_done", done5, 0);
    check("rst_bcd", bcd5, 0);
    check("rst_ovf", ovf5, 0);
    check("rst_bcd4", bcd4, 0);
    rst = 1'b0;
    @(negedge clk);
    prev_bcd = 20'h0;

    for (int i = 0; i < 12; i++) begin
      conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
    end

    // start pulsed mid-conversion must be ignored
    launch(16'd999);
    pulses = 0; d_lat = -1; got = '0;
    for (int c = 0; c < 30; c++) begin
      if (c == 5) begin start5 = 1'b1; bin5 = 16'd42; end
      else        start5 = 1'b0;
      if (done5) begin
        pulses++;
        if (pulses == 1) begin d_lat = c; got = bcd5; end
      end
      @(negedge clk);
    end
    start5 = 1'b0;
    check("ign_pulses", pulses, 1);
    check("ign_lat", d_lat, 16);
    check("ign_bcd", got, 20'h00999);
    prev_bcd = 20'h00999;

    // reset in the middle of a conversion
    launch(16'd5000);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy5, 0);
    check("abort_bcd", bcd5, 0);
    check("abort_ovf", ovf5, 0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (done5) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", pulses, 0);
    prev_bcd = 20'h0;
    conv("after_abort", 16'd7, 20'h00007, 1'b0);

    // back-to-back: next start issued in the done cycle
    launch(16'd321);
    wait_done(lat, bc, held);
    check("b2b_first_lat", lat, 16);
    check("b2b_first_bcd", bcd5, 20'h00321);
    prev_bcd = 20'h00321;
    launch(16'd10);
    wait_done(lat, bc, held);
    check("b2b_second_lat", lat, 16);
    check("b2b_hold", held, 1);
    check("b2b_second_bcd", bcd5, 20'h00010);
    prev_bcd = 20'h00010;
    @(negedge clk);

    // 4-digit instance: overflow saturation and its boundary
    sel = 1;
    prev_bcd = 20'h0;
    conv("d4_12345", 16'd12345, 20'h09999, 1'b1);
    conv("d4_9999",  16'd9999,  20'h09999, 1'b0);
    conv("d4_10000", 16'd10000, 20'h09999, 1'b1);
    conv("d4_42",    16'd42,    20'h00042, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
